// File: rtl/seg_ascii_pkg.sv
// Shared segment/ASCII definitions for the 7-segment <-> ASCII converters.
// Segment patterns are active-low, bit6=G .. bit0=A.
package seg_ascii_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [7:0] ascii_t;

  localparam seg_t SEG_H     = 7'b0001001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_L     = 7'b1000111;
  localparam seg_t SEG_O     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam ascii_t ASC_H     = 8'h48;
  localparam ascii_t ASC_E     = 8'h45;
  localparam ascii_t ASC_L     = 8'h4C;
  localparam ascii_t ASC_O     = 8'h4F;
  localparam ascii_t ASC_1     = 8'h31;
  localparam ascii_t ASC_2     = 8'h32;
  localparam ascii_t ASC_3     = 8'h33;
  localparam ascii_t ASC_4     = 8'h34;
  localparam ascii_t ASC_SPACE = 8'h20;
  localparam ascii_t ASC_QMARK = 8'h3F;

endpackage

// File: rtl/seg_ascii_decoder_if.sv
// Segment-in / ASCII-out handshake bundle. master = producer+consumer side,
// slave = the decoder.
interface seg_ascii_decoder_if;
  import seg_ascii_pkg::*;

  seg_t   seg_in;
  logic   seg_valid;
  logic   seg_ready;
  ascii_t ascii_out;
  logic   ascii_valid;
  logic   ascii_ready;

  modport master (
    output seg_in, seg_valid, ascii_ready,
    input  seg_ready, ascii_out, ascii_valid
  );

  modport slave (
    input  seg_in, seg_valid, ascii_ready,
    output seg_ready, ascii_out, ascii_valid
  );
endinterface

// File: rtl/seg_ascii_decoder_sync_fifo.sv
// First-word-fall-through FIFO, synchronous active-high reset.
// Head entry is read combinationally from mem[rd_ptr]; occupancy kept in level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push, pop;

  assign wr_ready = (level_q != LVL_FULL);
  assign rd_valid = (level_q != '0);
  assign rd_data  = mem[rd_ptr_q];
  assign level    = level_q;
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_ready && rd_valid;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately not reset; a flush only moves the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/seg_ascii_decoder.sv
// Active-low 7-segment pattern -> ASCII decoder feeding a FWFT FIFO.
// Optional unrecognised-pattern counter enabled by SEG_ASCII_DEC_ERRCNT_EN.
module seg_ascii_decoder
  import seg_ascii_pkg::*;
#(
  parameter int     DEPTH    = 8,
  parameter ascii_t UNK_CHAR = 8'h3F
) (
  input  logic                   clk,
  input  logic                   rst,
  seg_ascii_decoder_if.slave     bus,
  output logic                   unk_seen,
  output logic [$clog2(DEPTH):0] level
`ifdef SEG_ASCII_DEC_ERRCNT_EN
  ,
  output logic [15:0]            unk_count
`endif
);
  ascii_t dec_char;
  logic   dec_unk;
  logic   fifo_wr_ready;
  logic   push;
  logic   unk_seen_q, unk_seen_d;

  always_comb begin
    dec_char = UNK_CHAR;
    dec_unk  = 1'b0;
    case (bus.seg_in)
      SEG_H:     dec_char = ASC_H;
      SEG_E:     dec_char = ASC_E;
      SEG_L:     dec_char = ASC_L;
      SEG_O:     dec_char = ASC_O;  // digit 0 shares this pattern
      SEG_1:     dec_char = ASC_1;
      SEG_2:     dec_char = ASC_2;
      SEG_3:     dec_char = ASC_3;
      SEG_4:     dec_char = ASC_4;
      SEG_BLANK: dec_char = ASC_SPACE;
      default:   dec_unk  = 1'b1;
    endcase
  end

  assign push          = bus.seg_valid && fifo_wr_ready;
  assign bus.seg_ready = fifo_wr_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (dec_char),
    .wr_valid (bus.seg_valid),
    .wr_ready (fifo_wr_ready),
    .rd_data  (bus.ascii_out),
    .rd_valid (bus.ascii_valid),
    .rd_ready (bus.ascii_ready),
    .level    (level)
  );

  always_comb begin
    unk_seen_d = unk_seen_q | (push && dec_unk);
  end

  always_ff @(posedge clk) begin
    if (rst) unk_seen_q <= 1'b0;
    else     unk_seen_q <= unk_seen_d;
  end

  assign unk_seen = unk_seen_q;

`ifdef SEG_ASCII_DEC_ERRCNT_EN
  logic [15:0] unk_count_q, unk_count_d;

  always_comb begin
    unk_count_d = unk_count_q;
    if (push && dec_unk && (unk_count_q != 16'hFFFF))
      unk_count_d = unk_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) unk_count_q <= 16'd0;
    else     unk_count_q <= unk_count_d;
  end

  assign unk_count = unk_count_q;
`endif
endmodule

// File: tb/tb_seg_ascii_decoder.sv
// Directed + randomized bench for seg_ascii_decoder; reference model is a
// byte queue fed through a pattern lookup table.
module tb_seg_ascii_decoder;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_ascii_decoder_if bus();
  logic       unk_seen;
  logic [3:0] level;
`ifdef SEG_ASCII_DEC_ERRCNT_EN
  logic [15:0] unk_count;
`endif

  seg_ascii_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .unk_seen  (unk_seen),
    .level     (level)
`ifdef SEG_ASCII_DEC_ERRCNT_EN
    ,
    .unk_count (unk_count)
`endif
  );

  // Reference: known patterns and their characters
  logic [6:0] pat_tab [9] = '{7'b0001001, 7'b0000110, 7'b1000111, 7'b1000000,
                              7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b1111111};
  logic [7:0] chr_tab [9] = '{8'h48, 8'h45, 8'h4C, 8'h4F,
                              8'h31, 8'h32, 8'h33, 8'h34, 8'h20};

  logic [7:0] q [$];
  bit         m_unk;
  int         m_cnt;
  int         checks   = 0;
  int         failures = 0;

  function automatic bit known(input logic [6:0] p);
    for (int i = 0; i < 9; i++) if (pat_tab[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] ref_dec(input logic [6:0] p);
    for (int i = 0; i < 9; i++) if (pat_tab[i] == p) return chr_tab[i];
    return 8'h3F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("seg_ready", 32'(bus.seg_ready), 32'(q.size() < DEPTH));
    chk("ascii_valid", 32'(bus.ascii_valid), 32'(q.size() > 0));
    chk("level", 32'(level), 32'(q.size()));
    if (q.size() > 0) chk("ascii_out", 32'(bus.ascii_out), 32'(q[0]));
    chk("unk_seen", 32'(unk_seen), 32'(m_unk));
`ifdef SEG_ASCII_DEC_ERRCNT_EN
    chk("unk_count", 32'(unk_count), 32'(m_cnt));
`endif
  endtask

  // One clock: drive, check current state, advance, update model.
  task automatic cycle(input logic [6:0] s, input logic v, input logic r, input logic rs);
    bit acc_push, acc_pop;
    rst = rs;
    bus.seg_in = s;
    bus.seg_valid = v;
    bus.ascii_ready = r;
    check_outputs();
    acc_push = v && (q.size() < DEPTH);
    acc_pop  = r && (q.size() > 0);
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      m_unk = 1'b0;
      m_cnt = 0;
      $display("t=%0t reset", $time);
    end else begin
      if (acc_pop) void'(q.pop_front());
      if (acc_push) begin
        q.push_back(ref_dec(s));
        if (!known(s)) begin
          m_unk = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      if (acc_push || acc_pop)
        $display("t=%0t push=%0b seg=%07b pop=%0b level=%0d", $time, acc_push, s, acc_pop, q.size());
    end
  endtask

  function automatic logic [6:0] rand_pat();
    if ($urandom_range(0, 9) < 8) return pat_tab[$urandom_range(0, 8)];
    return 7'($urandom);
  endfunction

  initial begin
    logic [6:0] p;
    logic [6:0] hello [5];
    hello = '{7'b0001001, 7'b0000110, 7'b1000111, 7'b1000111, 7'b1000000};
    rst = 1'b1;
    bus.seg_in = '0;
    bus.seg_valid = 1'b0;
    bus.ascii_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    m_unk = 1'b0;
    m_cnt = 0;

    // Idle after reset
    cycle(7'h7F, 1'b0, 1'b0, 1'b0);
    cycle(7'h7F, 1'b0, 1'b1, 1'b0);

    // HELLO, then drain in order
    for (int i = 0; i < 5; i++) cycle(hello[i], 1'b1, 1'b0, 1'b0);
    chk("hello_level", 32'(level), 32'd5);
    for (int i = 0; i < 5; i++) cycle(7'h7F, 1'b0, 1'b1, 1'b0);
    cycle(7'h7F, 1'b0, 1'b1, 1'b0);

    // Fill to full, ninth held until a pop frees a slot
    for (int i = 0; i < 8; i++) cycle(rand_pat(), 1'b1, 1'b0, 1'b0);
    chk("full_level", 32'(level), 32'd8);
    chk("full_ready", 32'(bus.seg_ready), 32'd0);
    p = pat_tab[8];
    cycle(p, 1'b1, 1'b0, 1'b0);
    cycle(p, 1'b1, 1'b1, 1'b0);
    chk("after_pop_ready", 32'(bus.seg_ready), 32'd1);
    cycle(p, 1'b1, 1'b0, 1'b0);
    chk("ninth_level", 32'(level), 32'd8);
    for (int i = 0; i < 9; i++) cycle(7'h7F, 1'b0, 1'b1, 1'b0);

    // Steady push+pop at level 3 across pointer wrap
    for (int i = 0; i < 3; i++) cycle(rand_pat(), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(rand_pat(), 1'b1, 1'b1, 1'b0);
    chk("steady_level", 32'(level), 32'd3);
    for (int i = 0; i < 3; i++) cycle(7'h7F, 1'b0, 1'b1, 1'b0);

    // Unrecognised pattern
    cycle(7'b0000000, 1'b1, 1'b0, 1'b0);
    chk("unk_char", 32'(bus.ascii_out), 32'h3F);
    chk("unk_flag", 32'(unk_seen), 32'd1);
    cycle(7'h7F, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      cycle(rand_pat(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0 ? 0 : 1) | 1'(i % 40 > 25), 1'b0);

    // Flush at level 4
    while (q.size() > 0) cycle(7'h7F, 1'b0, 1'b1, 1'b0);
    cycle(7'b0000001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(rand_pat(), 1'b1, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd4);
    cycle(7'h7F, 1'b0, 1'b0, 1'b1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(bus.ascii_valid), 32'd0);
    chk("rst_unk", 32'(unk_seen), 32'd0);
    chk("rst_ready", 32'(bus.seg_ready), 32'd1);
    cycle(7'h7F, 1'b0, 1'b1, 1'b0);
    cycle(pat_tab[0], 1'b1, 1'b0, 1'b0);
    cycle(7'h7F, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
